// File: rtl/pulse_pkg.sv
// pulse_pkg: shared FSM state type and default counter width for the pulse datapath
package pulse_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/pulse_phase_counter.sv
// pulse_phase_counter: loadable down-counter with zero flag
//   clk, reset (async active-low), load/load_val (load wins over decrement),
//   en (decrement, saturates at 0), cnt (current value), zero (cnt==0)
module pulse_phase_counter #(parameter int CNT_W = 8) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - CNT_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: command-driven pulse train controller
//   clk, reset (async active-low); cmd_valid/cmd_ready handshake with
//   cmd_width/cmd_gap/cmd_count; abort cancels a running train;
//   pulse_out train, busy, done strobe, pulses_left
module pulse_sequencer import pulse_pkg::*; #(parameter int CNT_W = CNT_W_DEF) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_width,
  input  logic [CNT_W-1:0] cmd_gap,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left
);
  state_t state, state_nx;
  logic [CNT_W-1:0] width_r, gap_r, ph_cnt, ph_val;
  logic ph_zero, ph_load, accept, zero_cmd;
  assign accept = cmd_valid && state == IDLE;
  assign zero_cmd = cmd_width == '0 || cmd_count == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    unique case (state)
      IDLE: state_nx = (accept && !zero_cmd) ? HIGH : IDLE;
      HIGH: state_nx = abort ? IDLE : !ph_zero ? HIGH : pulses_left == CNT_W'(1) ? IDLE : gap_r != '0 ? LOW : HIGH;
      LOW:  state_nx = abort ? IDLE : ph_zero ? HIGH : LOW;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready = state == IDLE;
    busy = state != IDLE;
    pulse_out = state == HIGH;
  end
  // Reload on entering a phase, including HIGH->HIGH when gap==0 merges pulses
  assign ph_load = (state_nx == HIGH && (state != HIGH || ph_zero)) || (state_nx == LOW && state == HIGH);
  assign ph_val = state_nx == LOW ? gap_r - CNT_W'(1) : (state == IDLE ? cmd_width : width_r) - CNT_W'(1);
  pulse_phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk(clk), .reset(reset), .load(ph_load), .load_val(ph_val), .en(1'b1), .cnt(ph_cnt), .zero(ph_zero)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      width_r <= '0;
      gap_r <= '0;
      pulses_left <= '0;
      done <= 1'b0;
    end else begin
      done <= (accept && zero_cmd) || (state == HIGH && !abort && ph_zero && pulses_left == CNT_W'(1));
      if (accept) begin
        width_r <= cmd_width;
        gap_r <= cmd_gap;
      end
      pulses_left <= (accept && !zero_cmd) ? cmd_count : state_nx == IDLE ? '0 : (state == HIGH && ph_zero) ? pulses_left - CNT_W'(1) : pulses_left;
    end
endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
Command-driven controller for the pulse generation datapath. It accepts a pulse-train command over a valid/ready handshake: high width, low gap and pulse count. It then drives a registered pulse_out train with exact cycle counts. Its role is to sequence when and how long the pulse generator output is active, and it reports busy, done and the number of pulses remaining.

Parameters:
CNT_W, 8, width of the width, gap and count command fields and of the internal counters.

Ports:
clk  input  1  system clock; all state is updated on the rising edge.
reset  input  1  asynchronous, active-low reset; every register clears immediately while reset=0.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command; equals (state==IDLE).
cmd_width  input  CNT_W  high-phase length in clk cycles.
cmd_gap  input  CNT_W  low-phase length between pulses in clk cycles.
cmd_count  input  CNT_W  number of pulses.
abort  input  1  synchronous cancel of the running train.
pulse_out  output  1  registered pulse train.
busy  output  1  train in progress; equals (state!=IDLE).
done  output  1  one-cycle strobe when a train completes normally.
pulses_left  output  CNT_W  pulses not yet started, including the current one while in HIGH.

Behaviour:
- Reset values: state=IDLE, pulse_out=0, done=0, busy=0, cmd_ready=1, pulses_left=0, all counters 0.
- States are IDLE, HIGH and LOW. pulse_out=1 only in HIGH, and it is driven from the state register with no glitches.
- Accept occurs when cmd_valid and cmd_ready are both high at a rising edge. At that edge the controller latches width, gap and count.
- Zero command (width==0 or count==0): the controller stays in IDLE, done=1 on the next cycle, and pulse_out never rises.
- Normal start: at the accept edge go to HIGH and load phase_cnt=width-1, pulses_left=count. pulse_out is high starting with the first cycle after accept.
- HIGH, while phase_cnt!=0: decrement phase_cnt. HIGH therefore lasts exactly width cycles.
- HIGH end, when pulses_left==1: go to IDLE, pulses_left=0, done=1 for one cycle. There is no trailing gap.
- HIGH end, when pulses_left>1 and gap!=0: go to LOW, phase_cnt=gap-1, pulses_left decrements by 1.
- HIGH end, when pulses_left>1 and gap==0: stay in HIGH, reload phase_cnt=width-1, pulses_left decrements by 1. pulse_out stays high continuously, which is a legal merged train.
- LOW: lasts exactly gap cycles, then go to HIGH with phase_cnt=width-1.
- Back-to-back commands: in the cycle where done=1 the state is already IDLE, so cmd_ready=1 and a new command can be accepted at that same edge.
- abort: checked only when state!=IDLE. At the next edge the controller goes to IDLE, pulse_out=0, pulses_left=0, and done is NOT asserted. abort has higher priority than all phase transitions. abort in IDLE is ignored and does not block an accept in the same cycle.
- Asserting reset mid-train clears pulse_out immediately (asynchronously). No done strobe follows.
- cmd_* inputs are ignored while busy=1. Latched values do not change mid-train.
- Counter arithmetic is unsigned CNT_W-bit. The maximum is width=gap=count=2^CNT_W-1, and no counter ever wraps.

Decomposition:
- Shared package pulse_pkg holds:
  - the state enum {IDLE, HIGH, LOW};
  - the default CNT_W localparam, shared with the divider-based pulse datapath.
- One sub-module is natural: pulse_phase_counter, a loadable CNT_W down-counter with a zero flag and an asynchronous active-low reset. It is instantiated once for phase timing. pulses_left is kept in the top level.

Test Plan:
- Reset: hold reset=0 for 3 cycles with cmd_valid=1. Then pulse_out=0, done=0, busy=0, cmd_ready=1. Release reset: the command is accepted at the first edge.
- width=3, gap=2, count=2, accepted at edge 0. Then pulse_out=1 in cycles 1-3, 0 in cycles 4-5, 1 in cycles 6-8. done=1 only in cycle 9, with pulse_out=0 and busy=0. pulses_left reads 2 in cycles 1-3 and 1 from cycle 4 on.
- width=2, gap=0, count=3. Then pulse_out=1 for 6 consecutive cycles and done strobes in cycle 7.
- width=0, count=5 (and separately width=4, count=0). Then pulse_out stays 0 and done=1 in the cycle after accept.
- width=4, gap=4, count=3, with abort=1 in cycle 6 (the LOW phase). Then state=IDLE and pulse_out=0 in cycle 7, done is never asserted, and a new command offered in cycle 7 is accepted.
- Back-to-back: a second command (width=1, gap=1, count=1) is held valid throughout the first train. It is accepted exactly in the done cycle, and pulse_out=1 in the following cycle.
- Edge widths: width=255, gap=255, count=2 with CNT_W=8. Then the high phase measures 255 cycles, the gap measures 255 cycles, and no wrap occurs.
